psr_icc_unit: RTL and testbench

- Processor State Register (PSR) and Window Invalid Mask (WIM) holder for the SPARC core; sits directly downstream of ALU_32bit.
- Latches the N/Z/V/C flags the ALU produces on S-variant ops into PSR.icc.
- Feeds the carry back to the ALU's carry input.
- Maintains CWP for SAVE/RESTORE/trap/RETT with WIM-based overflow/underflow detection, and applies WRPSR writes through a programmable delay line.

---
 rtl/psr_pkg.sv | 32 +++
 rtl/psr_wr_delay.sv | 58 +++++
 rtl/psr_icc_unit.sv | 193 +++++++++++++++++++
 tb/tb_psr_icc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared PSR definitions: field bit positions, reset image and the icc flag struct.
package psr_pkg;

   localparam int PSR_N       = 23;
   localparam int PSR_Z       = 22;
   localparam int PSR_V       = 21;
   localparam int PSR_C       = 20;
   localparam int PSR_EC      = 13;
   localparam int PSR_EF      = 12;
   localparam int PSR_PIL_MSB = 11;
   localparam int PSR_PIL_LSB = 8;
   localparam int PSR_S       = 7;
   localparam int PSR_PS      = 6;
   localparam int PSR_ET      = 5;
   localparam int PSR_CWP_MSB = 4;
   localparam int PSR_CWP_LSB = 0;

   // Writable-field reset image; impl/ver are merged in by the top.
   localparam logic [31:0] PSR_RST = 32'h0000_0080;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } icc_t;

   function automatic icc_t icc_of(input logic [31:0] psr);
      return icc_t'(psr[PSR_N:PSR_C]);
   endfunction

endpackage

// File: rtl/psr_wr_delay.sv
// psr_wr_delay: WRPSR shift line with per-stage valid bits and an in-flight indicator.
// Latency: out_vld appears DELAY-1 edges after in_vld (the PSR register is the final stage).
// Backpressure: none; one entry may enter every cycle and entries leave strictly in order.
module psr_wr_delay #(
   parameter int DELAY = 3,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   output logic         pending
);

   // Commit happens on the PSR edge itself, so DELAY=0 and DELAY=1 both need no storage.
   localparam int NSTG = (DELAY > 1) ? DELAY - 1 : 0;

   generate
      if (NSTG == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ reset;
         assign out_vld = in_vld;
         assign out_dat = in_dat;
         assign pending = 1'b0;
      end else begin : g_line
         logic [NSTG-1:0]        vld_q, vld_d;
         logic [NSTG-1:0][W-1:0] dat_q, dat_d;

         always_comb begin
            vld_d    = vld_q;
            dat_d    = dat_q;
            vld_d[0] = in_vld;
            dat_d[0] = in_dat;
            for (int i = 1; i < NSTG; i++) begin
               vld_d[i] = vld_q[i-1];
               dat_d[i] = dat_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               vld_q <= '0;
               dat_q <= '0;
            end else begin
               vld_q <= vld_d;
               dat_q <= dat_d;
            end
         end

         assign out_vld = vld_q[NSTG-1];
         assign out_dat = dat_q[NSTG-1];
         assign pending = |vld_q;
      end
   endgenerate

endmodule

// File: rtl/psr_icc_unit.sv
// psr_icc_unit: SPARC PSR/WIM holder -- icc capture, CWP window control, delayed WRPSR.
// Latency: one edge per request; WRPSR commits WRPSR_DELAY edges after issue (min one).
// Backpressure: none; requests are applied or rejected with a pulse. Option macro: ICC_BYPASS_EN.
module psr_icc_unit
   import psr_pkg::*;
#(
   parameter int         NWINDOWS    = 8,
   parameter int         WRPSR_DELAY = 3,
   parameter logic [3:0] IMPL        = 4'h0,
   parameter logic [3:0] VER         = 4'h0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                icc_we,
   input  logic                N_in,
   input  logic                Z_in,
   input  logic                V_in,
   input  logic                C_in,
   input  logic                save,
   input  logic                restore,
   input  logic                trap_take,
   input  logic                rett,
   input  logic                wrpsr_en,
   input  logic [31:0]         wrpsr_data,
   input  logic                wim_we,
   input  logic [NWINDOWS-1:0] wim_data,
   output logic [31:0]         psr_out,
   output logic [NWINDOWS-1:0] wim_out,
   output logic                carry_out,
   output logic [4:0]          cwp,
   output logic                window_overflow,
   output logic                window_underflow,
   output logic                wrpsr_illegal,
   output logic                wrpsr_pending
);

   localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
   localparam logic [5:0] NWIN6   = 6'(NWINDOWS);

   icc_t                icc_q, icc_d;
   logic                ec_q, ec_d;
   logic                ef_q, ef_d;
   logic [3:0]          pil_q, pil_d;
   logic                s_q, s_d;
   logic                ps_q, ps_d;
   logic                et_q, et_d;
   logic [4:0]          cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                ill_q, ill_d;

   logic [4:0]          cwp_dec, cwp_inc;
   logic [NWINDOWS-1:0] wim_sh_dec, wim_sh_inc;
   logic                wim_blk_dec, wim_blk_inc;
   logic                wr_illegal, wr_acc;
   logic                commit_vld;
   logic [31:0]         commit_dat;
   logic                unused_commit_bits;

   assign cwp_dec     = (cwp_q == 5'd0)    ? CWP_MAX : cwp_q - 5'd1;
   assign cwp_inc     = (cwp_q == CWP_MAX) ? 5'd0    : cwp_q + 5'd1;
   assign wim_sh_dec  = wim_q >> cwp_dec;
   assign wim_sh_inc  = wim_q >> cwp_inc;
   assign wim_blk_dec = wim_sh_dec[0];
   assign wim_blk_inc = wim_sh_inc[0];

   assign wr_illegal = {1'b0, wrpsr_data[PSR_CWP_MSB:PSR_CWP_LSB]} >= NWIN6;
   assign wr_acc     = wrpsr_en & ~wr_illegal;

   psr_wr_delay #(
      .DELAY (WRPSR_DELAY),
      .W     (32)
   ) u_wr_delay (
      .clk     (clk),
      .reset   (reset),
      .in_vld  (wr_acc),
      .in_dat  (wrpsr_data),
      .out_vld (commit_vld),
      .out_dat (commit_dat),
      .pending (wrpsr_pending)
   );

   // impl/ver/reserved positions of a WRPSR operand are never written.
   assign unused_commit_bits = ^{commit_dat[31:24], commit_dat[19:14]};

   always_comb begin
      icc_d = icc_q;
      ec_d  = ec_q;
      ef_d  = ef_q;
      pil_d = pil_q;
      s_d   = s_q;
      ps_d  = ps_q;
      et_d  = et_q;
      cwp_d = cwp_q;
      wim_d = wim_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      ill_d = wrpsr_en & wr_illegal;

      // Committing WRPSR is applied first so same-cycle events overwrite its fields.
      if (commit_vld) begin
         icc_d = icc_of(commit_dat);
         ec_d  = commit_dat[PSR_EC];
         ef_d  = commit_dat[PSR_EF];
         pil_d = commit_dat[PSR_PIL_MSB:PSR_PIL_LSB];
         s_d   = commit_dat[PSR_S];
         ps_d  = commit_dat[PSR_PS];
         et_d  = commit_dat[PSR_ET];
         cwp_d = commit_dat[PSR_CWP_MSB:PSR_CWP_LSB];
      end

      if (icc_we) begin
         icc_d = '{n: N_in, z: Z_in, v: V_in, c: C_in};
      end

      if (trap_take) begin
         cwp_d = cwp_dec;
         ps_d  = s_q;
         s_d   = 1'b1;
         et_d  = 1'b0;
      end else if (rett) begin
         if (wim_blk_inc) begin
            unf_d = 1'b1;
         end else begin
            cwp_d = cwp_inc;
            s_d   = ps_q;
            et_d  = 1'b1;
         end
      end else if (save && !restore) begin
         if (wim_blk_dec) begin
            ovf_d = 1'b1;
         end else begin
            cwp_d = cwp_dec;
         end
      end else if (restore && !save) begin
         if (wim_blk_inc) begin
            unf_d = 1'b1;
         end else begin
            cwp_d = cwp_inc;
         end
      end

      if (wim_we) begin
         wim_d = wim_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         icc_q <= icc_of(PSR_RST);
         ec_q  <= PSR_RST[PSR_EC];
         ef_q  <= PSR_RST[PSR_EF];
         pil_q <= PSR_RST[PSR_PIL_MSB:PSR_PIL_LSB];
         s_q   <= PSR_RST[PSR_S];
         ps_q  <= PSR_RST[PSR_PS];
         et_q  <= PSR_RST[PSR_ET];
         cwp_q <= PSR_RST[PSR_CWP_MSB:PSR_CWP_LSB];
         wim_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         icc_q <= icc_d;
         ec_q  <= ec_d;
         ef_q  <= ef_d;
         pil_q <= pil_d;
         s_q   <= s_d;
         ps_q  <= ps_d;
         et_q  <= et_d;
         cwp_q <= cwp_d;
         wim_q <= wim_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         ill_q <= ill_d;
      end
   end

   assign psr_out = {IMPL, VER, icc_q, 6'b0, ec_q, ef_q, pil_q, s_q, ps_q, et_q, cwp_q};
   assign wim_out          = wim_q;
   assign cwp              = cwp_q;
   assign window_overflow  = ovf_q;
   assign window_underflow = unf_q;
   assign wrpsr_illegal    = ill_q;

`ifdef ICC_BYPASS_EN
   // Forward the live ALU carry so an ADDX can directly follow an ADDcc.
   assign carry_out = icc_we ? C_in : icc_q.c;
`else
   assign carry_out = icc_q.c;
`endif

endmodule

// File: tb/tb_psr_icc_unit.sv
// Directed bench for psr_icc_unit (NWINDOWS=8, WRPSR_DELAY=3): icc, windows, WRPSR, trap/rett, reset.
module tb_psr_icc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        icc_we, N_in, Z_in, V_in, C_in;
   logic        save, restore, trap_take, rett;
   logic        wrpsr_en;
   logic [31:0] wrpsr_data;
   logic        wim_we;
   logic [7:0]  wim_data;
   logic [31:0] psr_out;
   logic [7:0]  wim_out;
   logic        carry_out;
   logic [4:0]  cwp;
   logic        window_overflow, window_underflow, wrpsr_illegal, wrpsr_pending;

   int checks   = 0;
   int failures = 0;

   psr_icc_unit #(.NWINDOWS(8), .WRPSR_DELAY(3), .IMPL(4'h0), .VER(4'h0)) dut (
      .clk              (clk),
      .reset            (reset),
      .icc_we           (icc_we),
      .N_in             (N_in),
      .Z_in             (Z_in),
      .V_in             (V_in),
      .C_in             (C_in),
      .save             (save),
      .restore          (restore),
      .trap_take        (trap_take),
      .rett             (rett),
      .wrpsr_en         (wrpsr_en),
      .wrpsr_data       (wrpsr_data),
      .wim_we           (wim_we),
      .wim_data         (wim_data),
      .psr_out          (psr_out),
      .wim_out          (wim_out),
      .carry_out        (carry_out),
      .cwp              (cwp),
      .window_overflow  (window_overflow),
      .window_underflow (window_underflow),
      .wrpsr_illegal    (wrpsr_illegal),
      .wrpsr_pending    (wrpsr_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      icc_we = 0; N_in = 0; Z_in = 0; V_in = 0; C_in = 0;
      save = 0; restore = 0; trap_take = 0; rett = 0;
      wrpsr_en = 0; wrpsr_data = '0; wim_we = 0; wim_data = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      chk("rst_psr", psr_out, 32'h0000_0080);
      chk("rst_cwp", cwp, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_pending", wrpsr_pending, 0);
      chk("rst_wim", wim_out, 0);
      chk("rst_pulses", {window_overflow, window_underflow, wrpsr_illegal}, 0);

      // icc capture and carry
      icc_we = 1; N_in = 1; C_in = 1;
`ifdef ICC_BYPASS_EN
      #1 chk("bypass_carry", carry_out, 1);
`endif
      tick(); idle();
      chk("icc_psr", psr_out, 32'h0090_0080);
      chk("icc_carry", carry_out, 1);
      icc_we = 1;
      tick(); idle();
      chk("icc_clr_psr", psr_out, 32'h0000_0080);
      chk("icc_clr_carry", carry_out, 0);

      // save overflow, then wrap
      wim_we = 1; wim_data = 8'h80;
      tick(); idle();
      chk("wim_wr", wim_out, 8'h80);
      save = 1;
      tick(); idle();
      chk("save_ovf_pulse", window_overflow, 1);
      chk("save_ovf_cwp", cwp, 0);
      tick();
      chk("save_ovf_drop", window_overflow, 0);
      wim_we = 1; wim_data = 8'h00;
      tick(); idle();
      save = 1;
      tick(); idle();
      chk("save_wrap_cwp", cwp, 7);
      chk("save_wrap_ovf", window_overflow, 0);
      chk("save_wrap_psr", psr_out, 32'h0000_0087);

      // restore wrap, then underflow
      restore = 1;
      tick(); idle();
      chk("rest_wrap_cwp", cwp, 0);
      wim_we = 1; wim_data = 8'h02;
      tick(); idle();
      restore = 1;
      tick(); idle();
      chk("rest_unf_pulse", window_underflow, 1);
      chk("rest_unf_cwp", cwp, 0);
      tick();
      chk("rest_unf_drop", window_underflow, 0);

      // same-cycle WIM write: save sees the old WIM (bit7 clear)
      save = 1; wim_we = 1; wim_data = 8'hFF;
      tick(); idle();
      chk("save_oldwim_cwp", cwp, 7);
      chk("save_oldwim_ovf", window_overflow, 0);
      chk("save_oldwim_wim", wim_out, 8'hFF);
      wim_we = 1; wim_data = 8'h00;
      tick(); idle();

      // save and restore together: no-op
      save = 1; restore = 1;
      tick(); idle();
      chk("both_cwp", cwp, 7);
      chk("both_pulses", {window_overflow, window_underflow}, 0);

      // delayed WRPSR
      wrpsr_en = 1; wrpsr_data = 32'h0000_0F23;
      tick(); idle();
      chk("wr_d1_psr", psr_out, 32'h0000_0087);
      chk("wr_d1_pend", wrpsr_pending, 1);
      tick();
      chk("wr_d2_psr", psr_out, 32'h0000_0087);
      chk("wr_d2_pend", wrpsr_pending, 1);
      tick();
      chk("wr_d3_psr", psr_out, 32'h0000_0F23);
      chk("wr_d3_pend", wrpsr_pending, 0);
      chk("wr_d3_cwp", cwp, 3);

      // illegal CWP value
      wrpsr_en = 1; wrpsr_data = 32'h0000_0009;
      tick(); idle();
      chk("ill_pulse", wrpsr_illegal, 1);
      chk("ill_pend", wrpsr_pending, 0);
      tick();
      chk("ill_drop", wrpsr_illegal, 0);
      tick(); tick();
      chk("ill_psr", psr_out, 32'h0000_0F23);

      // trap then rett from S=0, CWP=2
      wrpsr_en = 1; wrpsr_data = 32'h0000_0002;
      tick(); idle();
      tick(); tick();
      chk("trap_setup", psr_out, 32'h0000_0002);
      trap_take = 1;
      tick(); idle();
      chk("trap_psr", psr_out, 32'h0000_0081);
      rett = 1;
      tick(); idle();
      chk("rett_psr", psr_out, 32'h0000_0022);
      wim_we = 1; wim_data = 8'h08;
      tick(); idle();
      rett = 1;
      tick(); idle();
      chk("rett_fail_unf", window_underflow, 1);
      chk("rett_fail_psr", psr_out, 32'h0000_0022);
      wim_we = 1; wim_data = 8'h00;
      tick(); idle();

      // back-to-back WRPSR commit in order
      wrpsr_en = 1; wrpsr_data = 32'h0000_0F21;
      tick();
      wrpsr_data = 32'h0000_0124;
      tick(); idle();
      chk("b2b_e2_psr", psr_out, 32'h0000_0022);
      tick();
      chk("b2b_e3_psr", psr_out, 32'h0000_0F21);
      chk("b2b_e3_pend", wrpsr_pending, 1);
      tick();
      chk("b2b_e4_psr", psr_out, 32'h0000_0124);
      chk("b2b_e4_pend", wrpsr_pending, 0);

      // commit coinciding with icc_we and save
      wrpsr_en = 1; wrpsr_data = 32'h00F0_0A22;
      tick(); idle();
      tick();
      icc_we = 1; Z_in = 1; save = 1;
      tick(); idle();
      chk("conf_psr", psr_out, 32'h0040_0A23);
      chk("conf_carry", carry_out, 0);

      // reset discards an in-flight write
      wrpsr_en = 1; wrpsr_data = 32'h0000_0F25;
      tick(); idle();
      reset = 1;
      tick();
      reset = 0;
      chk("rstmid_psr", psr_out, 32'h0000_0080);
      chk("rstmid_pend", wrpsr_pending, 0);
      tick(); tick(); tick();
      chk("rstmid_late_psr", psr_out, 32'h0000_0080);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
